instr_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage directly upstream of the main decoder.
- Holds the PC and fetches the instruction word from instruction memory over a req/ready handshake. Presents a registered instruction, whose opcode field feeds the decoder.
- Takes the decoder's PCSrc decision, together with the extended immediate, and computes the next PC.
- Traps on misaligned targets.

---
 rtl/instr_fetch_unit_if.sv | 22 ++
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
// The fetch unit drives the master side; memory (or the bench) drives the slave side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC register and instruction-fetch sequencer feeding the main decoder.
// Define FETCH_PERF_CNT_EN to add the retired/stall performance counters.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_BOOT  | one idle cycle after reset release, no request
// ST_FETCH | request imem at pc until imem_ready, count wait cycles
// ST_EXEC  | instr live for the decoder; advance pc unless stalled
// ST_HALT  | misaligned target seen; NOP presented until reset
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned WAIT_MAX  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  imem,
    input  logic                pc_src,
    input  logic [31:0]         imm_ext,
    input  logic                stall,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                misalign_err,
    output logic                fetch_timeout
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         retired_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       next_pc;

    assign pc_plus4 = pc_q + 32'd4;
    assign next_pc  = pc_src ? (pc_q + imm_ext) : pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            wait_q     <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            wait_q     <= wait_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_d     = wait_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    wait_d  = '0;
                    state_d = ST_EXEC;
                end else begin
                    if (wait_q != WAIT_LIM) begin
                        wait_d = wait_q + WAIT_ONE;
                    end
                    // Informational only: the fetch keeps requesting after the flag sets.
                    if (wait_d == WAIT_LIM) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        instr_d    = NOP_INSTR;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                instr_d = NOP_INSTR;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == ST_EXEC);
    assign pc             = pc_q;
    assign misalign_err   = misalign_q;
    assign fetch_timeout  = timeout_q;

`ifdef FETCH_PERF_CNT_EN
    logic        exec_retire;
    logic        exec_stall;
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign exec_retire = (state_q == ST_EXEC) && !stall && (next_pc[1:0] == 2'b00);
    assign exec_stall  = (state_q == ST_EXEC) && stall;

    always_comb begin
        retired_d   = retired_q;
        stall_cnt_d = stall_cnt_q;
        if (exec_retire) begin
            retired_d = retired_q + 32'd1;
        end
        if (exec_stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            retired_q   <= retired_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed literal checks plus a randomized run
// compared every cycle against a transaction-level model of the fetch stage.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          WMAX     = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_src;
    logic [31:0] imm_ext;
    logic        stall;
    logic [31:0] instr, pc, pc_plus4;
    logic        instr_valid, misalign_err, fetch_timeout;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif
    logic        rdy;
    int          mem_mode;
    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int mode);
        if (mode == 0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    instr_fetch_unit_if bus();
    assign bus.imem_ready = rdy;
    assign bus.imem_rdata = mem_word(bus.imem_addr, mem_mode);

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (bus),
        .pc_src       (pc_src),
        .imm_ext      (imm_ext),
        .stall        (stall),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err),
        .fetch_timeout(fetch_timeout)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_cnt  (retired_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    // Transaction-level model: which phase of the instruction lifecycle we are in,
    // the architectural pc, and the sticky flags.
    bit          m_boot, m_fetch, m_exec, m_halt, m_err, m_to;
    logic [31:0] m_pc, m_instr, m_ret, m_stl;
    int          m_waits;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] tgt;
        if (!rst_n) begin
            m_boot <= 1'b1; m_fetch <= 1'b0; m_exec <= 1'b0; m_halt <= 1'b0;
            m_err <= 1'b0; m_to <= 1'b0; m_pc <= RESET_PC; m_instr <= NOP;
            m_waits <= 0; m_ret <= '0; m_stl <= '0;
        end else if (m_boot) begin
            m_boot <= 1'b0; m_fetch <= 1'b1;
        end else if (m_fetch) begin
            if (bus.imem_ready) begin
                m_instr <= mem_word(m_pc, mem_mode);
                m_waits <= 0; m_fetch <= 1'b0; m_exec <= 1'b1;
            end else begin
                if (m_waits < WMAX) m_waits <= m_waits + 1;
                if (m_waits + 1 >= WMAX) m_to <= 1'b1;
            end
        end else if (m_exec) begin
            if (stall) begin
                m_stl <= m_stl + 32'd1;
            end else begin
                tgt = pc_src ? m_pc + imm_ext : m_pc + 32'd4;
                if (tgt[1:0] != 2'b00) begin
                    m_err <= 1'b1; m_exec <= 1'b0; m_halt <= 1'b1; m_instr <= NOP;
                end else begin
                    m_pc <= tgt; m_exec <= 1'b0; m_fetch <= 1'b1; m_ret <= m_ret + 32'd1;
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("imem_req",      32'(bus.imem_req),  32'(m_fetch));
            cmp("imem_addr",     bus.imem_addr,      m_pc);
            cmp("pc",            pc,                 m_pc);
            cmp("pc_plus4",      pc_plus4,           m_pc + 32'd4);
            cmp("instr_valid",   32'(instr_valid),   32'(m_exec));
            cmp("misalign_err",  32'(misalign_err),  32'(m_err));
            cmp("fetch_timeout", 32'(fetch_timeout), 32'(m_to));
            if (m_exec || m_halt || m_boot) cmp("instr", instr, m_instr);
`ifdef FETCH_PERF_CNT_EN
            cmp("retired_cnt", retired_cnt, m_ret);
            cmp("stall_cnt",   stall_cnt,   m_stl);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_exec(input string nm);
        for (int k = 0; k < 60 && !instr_valid; k++) tick();
        cmp({"reach_exec_", nm}, 32'(instr_valid), 32'd1);
    endtask

    task automatic exec_one(input logic src, input logic [31:0] imm, input int nst);
        wait_exec("exec_one");
        stall = 1'b1;
        repeat (nst) tick();
        stall = 1'b0; pc_src = src; imm_ext = imm;
        tick();
        pc_src = 1'b0; imm_ext = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        int s;
        stall = 1'b0; pc_src = 1'b0; imm_ext = '0; rdy = 1'b1; mem_mode = 0;
        chk_en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;

        // Boot and first instruction with a zero-wait memory.
        cmp("boot_req",   32'(bus.imem_req), 32'd0);
        cmp("boot_pc",    pc,                RESET_PC);
        cmp("boot_instr", instr,             NOP);
        cmp("boot_valid", 32'(instr_valid),  32'd0);
        tick();
        cmp("f1_req",  32'(bus.imem_req), 32'd1);
        cmp("f1_addr", bus.imem_addr,     32'h0);
        tick();
        cmp("e1_instr", instr,            32'h0050_0093);
        cmp("e1_valid", 32'(instr_valid), 32'd1);
        tick();
        cmp("f2_pc",   pc,                32'h4);
        cmp("f2_req",  32'(bus.imem_req), 32'd1);
        tick();
        cmp("e2_valid", 32'(instr_valid), 32'd1);

        // Walk to 0x10, then taken branch back by 8.
        exec_one(1'b0, '0, 0);
        exec_one(1'b0, '0, 0);
        exec_one(1'b0, '0, 0);
        cmp("at_10", pc, 32'h10);
        exec_one(1'b1, 32'hFFFF_FFF8, 0);
        cmp("br_taken_addr", bus.imem_addr, 32'h08);
        exec_one(1'b0, '0, 0);
        exec_one(1'b0, '0, 0);
        exec_one(1'b0, 32'h0000_1234, 0);
        cmp("br_not_taken_addr", bus.imem_addr, 32'h14);

        // Three stall cycles hold everything in place.
        wait_exec("stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("stall_instr", instr,            32'h0050_0093);
            cmp("stall_pc",    pc,               32'h14);
            cmp("stall_valid", 32'(instr_valid), 32'd1);
            cmp("stall_req",   32'(bus.imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        cmp("unstall_pc", pc, 32'h18);

        exec_one(1'b1, 32'h0, 0);
        cmp("self_loop_pc", pc, 32'h18);

        // Wrap-around of the 32-bit pc.
        do_reset();
        exec_one(1'b1, 32'hFFFF_FFFC, 0);
        cmp("wrap_pc",    pc,       32'hFFFF_FFFC);
        cmp("wrap_plus4", pc_plus4, 32'h0);
        exec_one(1'b0, '0, 0);
        cmp("wrap_to_0", pc, 32'h0);

        // Misaligned branch target halts with pc held.
        exec_one(1'b1, 32'h20, 0);
        wait_exec("mis");
        pc_src = 1'b1; imm_ext = 32'h2;
        tick();
        pc_src = 1'b0; imm_ext = '0;
        cmp("mis_err",   32'(misalign_err), 32'd1);
        cmp("mis_valid", 32'(instr_valid),  32'd0);
        cmp("mis_instr", instr,             NOP);
        repeat (3) tick();
        cmp("halt_pc",  pc,                32'h20);
        cmp("halt_req", 32'(bus.imem_req), 32'd0);

        // Slow memory: timeout flag after 15 waiting cycles, fetch continues.
        rdy = 1'b0;
        do_reset();
        tick();
        repeat (14) tick();
        cmp("to_before", 32'(fetch_timeout), 32'd0);
        tick();
        cmp("to_at15", 32'(fetch_timeout), 32'd1);
        repeat (5) tick();
        cmp("to_req_held", 32'(bus.imem_req), 32'd1);
        rdy = 1'b1;
        tick();
        cmp("to_complete", 32'(instr_valid), 32'd1);
        tick();
        rdy = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        cmp("async_req", 32'(bus.imem_req),  32'd0);
        cmp("async_pc",  pc,                 RESET_PC);
        cmp("async_to",  32'(fetch_timeout), 32'd0);
        tick();
        rst_n = 1'b1;
        rdy = 1'b1;

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        exec_one(1'b0, '0, 1);
        exec_one(1'b0, '0, 1);
        exec_one(1'b0, '0, 0);
        exec_one(1'b0, '0, 0);
        exec_one(1'b0, '0, 0);
        cmp("perf_retired", retired_cnt, 32'd5);
        cmp("perf_stall",   stall_cnt,   32'd2);
`endif

        // Randomized traffic against the model.
        rst_n = 1'b0;
        mem_mode = 1;
        do_reset();
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            stall  = ($urandom_range(0, 3) == 0);
            pc_src = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, 31)) - 16;
            imm_ext = 32'(s * 4);
            if ($urandom_range(0, 39) == 0) imm_ext[1:0] = 2'($urandom_range(1, 3));
            if (burst > 0) begin
                rdy = 1'b0;
                burst--;
            end else begin
                if ($urandom_range(0, 149) == 0) burst = int'($urandom_range(10, 20));
                rdy = ($urandom_range(0, 2) != 0);
            end
            tick();
            if ((misalign_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end
        end

        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
